// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage core: stall/flush generation,
// operand forwarding selects, MDU wait sequencing and saturating event counters.
module pipeline_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wr_enable,
  input  logic             ex_mem_to_reg,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             branch,
  input  logic [4:0]       wb_rd,
  input  logic             wb_wr_enable,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             stall_execute,
  output logic             flush_decode,
  output logic             flush_execute,
  output logic             flush_memory,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MDU_TIMEOUT - 1);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic [4:0]    ret_rd;
  logic          ret_valid;

  logic load_use;
  logic mdu_release;
  logic branch_flush;

  assign load_use = ex_mem_to_reg && ex_wr_enable && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign mdu_release  = mdu_done || (wait_cnt == T_LAST);
  assign branch_flush = !rst && (state == RUN) && branch;

  // Hazard priority in RUN is branch, then MDU start, then load-use; MDU_WAIT ignores all of them.
  always_comb begin
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    stall_execute = 1'b0;
    flush_decode  = 1'b0;
    flush_execute = 1'b0;
    flush_memory  = 1'b0;
    forward_a     = 2'b00;
    forward_b     = 2'b00;
    if (!rst) begin
      case (state)
        RUN: begin
          if (branch) begin
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
          end else if (ex_mdu_start && !mdu_done) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            flush_memory  = 1'b1;
          end else if (load_use) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
          end
        end
        MDU_WAIT: begin
          if (!mdu_release) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            flush_memory  = 1'b1;
          end
        end
        default: ;
      endcase

      if (wb_wr_enable && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
        forward_a = 2'b01;
      else if (ret_valid && (ret_rd == ex_rs1))
        forward_a = 2'b10;

      if (wb_wr_enable && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
        forward_b = 2'b01;
      else if (ret_valid && (ret_rd == ex_rs2))
        forward_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      ret_rd      <= 5'd0;
      ret_valid   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      ret_rd    <= wb_rd;
      ret_valid <= wb_wr_enable && (wb_rd != 5'd0);

      if (stall_fetch && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (branch_flush && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);

      case (state)
        RUN: begin
          if (!branch && ex_mdu_start && !mdu_done) begin
            state    <= MDU_WAIT;
            wait_cnt <= '0;
          end
        end
        MDU_WAIT: begin
          // A done in the last counted cycle wins, so the error flag is only raised on a true timeout.
          if (mdu_done) begin
            state <= RUN;
          end else if (wait_cnt == T_LAST) begin
            state       <= RUN;
            mdu_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural model of the controller.
module tb_pipeline_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int C_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_wr_enable, ex_mem_to_reg;
  logic ex_mdu_start, mdu_done, branch, wb_wr_enable;
  logic stall_fetch, stall_decode, stall_execute;
  logic flush_decode, flush_execute, flush_memory;
  logic [1:0] forward_a, forward_b;
  logic mdu_timeout;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // Model state: whether an MDU op is outstanding and how many stall cycles it has cost so far.
  bit       m_wait;
  int       m_op_stalls;
  bit       m_ret_valid;
  bit [4:0] m_ret_rd;
  int       m_stall;
  int       m_flush;
  bit       m_to;

  pipeline_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_wr_enable(ex_wr_enable), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .branch(branch),
    .wb_rd(wb_rd), .wb_wr_enable(wb_wr_enable),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .flush_decode(flush_decode), .flush_execute(flush_execute), .flush_memory(flush_memory),
    .forward_a(forward_a), .forward_b(forward_b),
    .mdu_timeout(mdu_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (wb_wr_enable && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
    if (m_ret_valid && m_ret_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= C_MAX) ? C_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_op_stalls = 0; m_ret_valid = 0; m_ret_rd = 5'd0;
    m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  task automatic idle();
    rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_wr_enable = 0; ex_mem_to_reg = 0;
    ex_mdu_start = 0; mdu_done = 0; branch = 0; wb_rd = 0; wb_wr_enable = 0;
  endtask

  // Called at a falling edge with inputs already driven; checks, clocks, updates the model.
  task automatic applyStimulus();
    logic sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    bit lu, rel, timed_out;
    #1;
    {sf, sd, se, fd, fe, fm} = 6'b0;
    fa = 2'b00; fb = 2'b00;
    lu = ex_mem_to_reg && ex_wr_enable && ex_rd != 5'd0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    rel = m_wait && (mdu_done || m_op_stalls == TO);
    timed_out = m_wait && !mdu_done && m_op_stalls == TO;
    if (!rst) begin
      if (m_wait) begin
        if (!rel) {sf, sd, se, fm} = 4'b1111;
      end else if (branch) begin
        fd = 1; fe = 1;
      end else if (ex_mdu_start && !mdu_done) begin
        {sf, sd, se, fm} = 4'b1111;
      end else if (lu) begin
        sf = 1; sd = 1; fe = 1;
      end
      fa = model_fwd(ex_rs1);
      fb = model_fwd(ex_rs2);
    end
    checkOutput("stall_fetch", stall_fetch, sf);
    checkOutput("stall_decode", stall_decode, sd);
    checkOutput("stall_execute", stall_execute, se);
    checkOutput("flush_decode", flush_decode, fd);
    checkOutput("flush_execute", flush_execute, fe);
    checkOutput("flush_memory", flush_memory, fm);
    checkOutput("forward_a", forward_a, fa);
    checkOutput("forward_b", forward_b, fb);
    checkOutput("mdu_timeout", mdu_timeout, m_to);
    checkOutput("stall_count", stall_count, m_stall);
    checkOutput("flush_count", flush_count, m_flush);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (sf) m_stall = sat_inc(m_stall);
      if (!m_wait && branch) m_flush = sat_inc(m_flush);
      if (m_wait) begin
        if (rel) begin
          m_wait = 0;
          if (timed_out) m_to = 1;
        end else begin
          m_op_stalls++;
        end
      end else if (!branch && ex_mdu_start && !mdu_done) begin
        m_wait = 1;
        m_op_stalls = 1;
      end
      m_ret_valid = wb_wr_enable && wb_rd != 5'd0;
      m_ret_rd = wb_rd;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1; applyStimulus(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state with rst held
    do_reset();

    // Load-use: one bubble, then writeback forwarding
    idle(); ex_mem_to_reg = 1; ex_wr_enable = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1 checkOutput("lu_stall", {stall_fetch, stall_decode, flush_execute}, 3'b111);
    applyStimulus();
    idle(); wb_rd = 5; wb_wr_enable = 1; ex_rs1 = 5;
    #1 checkOutput("lu_fwd_a", forward_a, 2'b01);
    checkOutput("lu_no_stall", stall_fetch, 1'b0);
    checkOutput("lu_stall_count", stall_count, 1);
    applyStimulus();

    // x0 guard
    do_reset();
    idle(); ex_mem_to_reg = 1; ex_wr_enable = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1 checkOutput("x0_no_stall", stall_fetch, 1'b0);
    applyStimulus();
    idle(); wb_rd = 0; wb_wr_enable = 1; ex_rs1 = 0;
    #1 checkOutput("x0_fwd_a", forward_a, 2'b00);
    applyStimulus();
    idle(); applyStimulus();

    // Branch beats MDU start
    do_reset();
    idle(); branch = 1; ex_mdu_start = 1;
    #1 checkOutput("br_flush", {flush_decode, flush_execute, stall_fetch}, 3'b110);
    applyStimulus();
    idle();
    #1 checkOutput("br_run", stall_fetch, 1'b0);
    checkOutput("br_flush_count", flush_count, 1);
    applyStimulus();

    // MDU with done three cycles after start
    do_reset();
    idle(); ex_mdu_start = 1; applyStimulus();
    idle(); applyStimulus(); applyStimulus();
    mdu_done = 1;
    #1 checkOutput("mdu_done_release", {stall_fetch, flush_memory}, 2'b00);
    applyStimulus();
    idle();
    #1 checkOutput("mdu_stall_count", stall_count, 3);
    applyStimulus();

    // MDU timeout
    do_reset();
    idle(); ex_mdu_start = 1; applyStimulus();
    idle(); repeat (3) applyStimulus();
    #1 checkOutput("to_release", stall_fetch, 1'b0);
    applyStimulus();
    #1 checkOutput("to_flag", mdu_timeout, 1'b1);
    checkOutput("to_stall_count", stall_count, TO);
    repeat (3) applyStimulus();
    #1 checkOutput("to_sticky", mdu_timeout, 1'b1);
    applyStimulus();

    // Retired-write forwarding
    do_reset();
    idle(); wb_rd = 7; wb_wr_enable = 1; applyStimulus();
    idle(); ex_rs2 = 7;
    #1 checkOutput("ret_fwd_b", forward_b, 2'b10);
    applyStimulus();

    // Reset in the middle of an MDU wait
    idle(); ex_mdu_start = 1; applyStimulus();
    idle(); applyStimulus();
    rst = 1;
    #1 checkOutput("midrst_held", {stall_fetch, stall_decode, stall_execute, flush_memory}, 4'b0);
    applyStimulus();
    idle();
    #1 checkOutput("midrst_after", {stall_fetch, flush_memory}, 2'b00);
    checkOutput("midrst_count", stall_count, 0);
    applyStimulus();

    // Random traffic, small register indices to provoke matches; counters saturate quickly
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      id_rs1        = 5'($urandom_range(0, 5));
      id_rs2        = 5'($urandom_range(0, 5));
      id_use_rs1    = 1'($urandom);
      id_use_rs2    = 1'($urandom);
      ex_rs1        = 5'($urandom_range(0, 5));
      ex_rs2        = 5'($urandom_range(0, 5));
      ex_rd         = 5'($urandom_range(0, 5));
      ex_wr_enable  = 1'($urandom);
      ex_mem_to_reg = 1'($urandom);
      ex_mdu_start  = ($urandom_range(0, 5) == 0);
      mdu_done      = ($urandom_range(0, 3) == 0);
      branch        = ($urandom_range(0, 6) == 0);
      wb_rd         = 5'($urandom_range(0, 5));
      wb_wr_enable  = 1'($urandom);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
